// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of a 4-bit ALU: issues single ALU ops and
// unsigned multiplies by repeated shift-add through the same ALU.
module alu_op_sequencer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_cmd,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [2:0]           alu_op,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic                 alu_cout,
   input  logic                 alu_overflow,
   input  logic                 alu_zero,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_result,
   output logic                 out_cout,
   output logic                 out_overflow,
   output logic                 out_zero
);

   localparam int unsigned RES_W = 2 * WIDTH;
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [2:0]  OP_ADD = 3'b010;

   typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;       // operand A / multiplicand M
   logic [WIDTH-1:0]   b_q, b_d;       // operand B / multiplier Q (shifts)
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   phi_q, phi_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               valid_d, cout_d, ovf_d, zero_d;
   logic [RES_W-1:0]   res_d;
   logic [RES_W-1:0]   shift_c;

   assign in_ready = (state_q == IDLE);

   // {cout, sum, Q} shifted right by one: the next {P_hi, Q}
   assign shift_c = {alu_cout, alu_result, b_q[WIDTH-1:1]};

   // ALU drive is decoded from registered state only
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = 3'b000;
      case (state_q)
         EXEC: begin
            alu_a  = a_q;
            alu_b  = b_q;
            alu_op = op_q;
         end
         MUL: begin
            alu_a  = phi_q;
            alu_b  = b_q[0] ? a_q : '0;
            alu_op = OP_ADD;
         end
         default: ;
      endcase
   end

   // Next-state and next-register values
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      phi_d   = phi_q;
      cnt_d   = cnt_q;
      res_d   = out_result;
      cout_d  = out_cout;
      ovf_d   = out_overflow;
      zero_d  = out_zero;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               op_d    = in_cmd[2:0];
               phi_d   = '0;
               cnt_d   = '0;
               state_d = in_cmd[3] ? MUL : EXEC;
            end
         end
         EXEC: begin
            res_d   = RES_W'(alu_result);
            cout_d  = alu_cout;
            ovf_d   = alu_overflow;
            zero_d  = alu_zero;
            state_d = DONE;
         end
         MUL: begin
            {phi_d, b_d} = shift_c;
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               res_d   = shift_c;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               zero_d  = (shift_c == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= 3'b000;
         phi_q        <= '0;
         cnt_q        <= '0;
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_cout     <= 1'b0;
         out_overflow <= 1'b0;
         out_zero     <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         phi_q        <= phi_d;
         cnt_q        <= cnt_d;
         out_valid    <= valid_d;
         out_result   <= res_d;
         out_cout     <= cout_d;
         out_overflow <= ovf_d;
         out_zero     <= zero_d;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_ready, out_valid;
   logic [3:0] in_cmd, in_a, in_b, alu_a, alu_b, alu_result;
   logic [2:0] alu_op;
   logic       alu_cout, alu_overflow, alu_zero;
   logic       out_cout, out_overflow, out_zero;
   logic [7:0] out_result;
   logic [7:0] held;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
      .in_a(in_a), .in_b(in_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_cout(alu_cout),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_cout(out_cout), .out_overflow(out_overflow), .out_zero(out_zero)
   );

   // ALU model: op[2] inverts B and supplies carry-in; op[1:0] selects AND/OR/SUM/SLT
   logic [3:0] bb;
   logic [4:0] sum;
   always_comb begin
      bb  = alu_op[2] ? ~alu_b : alu_b;
      sum = {1'b0, alu_a} + {1'b0, bb} + {4'b0, alu_op[2]};
      alu_overflow = (alu_a[3] == bb[3]) && (sum[3] != alu_a[3]);
      alu_cout = sum[4];
      case (alu_op[1:0])
         2'b00:   alu_result = alu_a & bb;
         2'b01:   alu_result = alu_a | bb;
         2'b10:   alu_result = sum[3:0];
         default: alu_result = {3'b000, sum[3] ^ alu_overflow};
      endcase
      alu_zero = (alu_result == 4'b0000);
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
      #12;
      check("rst_in_ready", 8'(in_ready), 8'h01);
      check("rst_out_valid", 8'(out_valid), 8'h00);
      check("rst_out_result", out_result, 8'h00);
      check("rst_alu_op", 8'(alu_op), 8'h00);
      rst_n = 1'b1;
      step();

      // ADD 7+7
      in_valid = 1'b1; in_cmd = 4'b0010; in_a = 4'b0111; in_b = 4'b0111;
      step();
      in_valid = 1'b0;
      check("add_exec_alu_a", 8'(alu_a), 8'h07);
      check("add_exec_alu_b", 8'(alu_b), 8'h07);
      check("add_exec_alu_op", 8'(alu_op), 8'h02);
      check("add_exec_valid", 8'(out_valid), 8'h00);
      step();
      check("add_valid", 8'(out_valid), 8'h01);
      check("add_result", out_result, 8'h0E);
      check("add_flags", {5'b0, out_cout, out_overflow, out_zero}, 8'b010);
      check("done_alu_op", 8'(alu_op), 8'h00);
      // backpressure for 5 cycles
      held = out_result;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", 8'(out_valid), 8'h01);
         check("bp_result", out_result, held);
         check("bp_in_ready", 8'(in_ready), 8'h00);
      end
      // release; a command presented on the same edge must not be taken
      out_ready = 1'b1; in_valid = 1'b1; in_cmd = 4'b0110; in_a = 4'b0111; in_b = 4'b0111;
      step();
      out_ready = 1'b0;
      check("rel_in_ready", 8'(in_ready), 8'h01);
      check("rel_out_valid", 8'(out_valid), 8'h00);

      // SUB 7-7, accepted now
      step();
      in_valid = 1'b0;
      check("sub_exec_alu_op", 8'(alu_op), 8'h06);
      step();
      check("sub_result", out_result, 8'h00);
      check("sub_flags", {6'b0, out_overflow, out_zero}, 8'b01);
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // SLT -7 < -1
      in_valid = 1'b1; in_cmd = 4'b0111; in_a = 4'b1001; in_b = 4'b1111;
      step(); in_valid = 1'b0; step();
      check("slt_result", out_result, 8'h01);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      in_valid = 1'b1; in_cmd = 4'b0111; in_a = 4'b1111; in_b = 4'b1001;
      step(); in_valid = 1'b0; step();
      check("slt_swap_result", out_result, 8'h00);
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // MUL 15*15
      in_valid = 1'b1; in_cmd = 4'b1000; in_a = 4'b1111; in_b = 4'b1111;
      step(); in_valid = 1'b0;
      check("mul_first_alu_a", 8'(alu_a), 8'h00);
      check("mul_first_alu_b", 8'(alu_b), 8'h0F);
      for (int i = 0; i < 4; i++) begin
         check("mul_alu_op", 8'(alu_op), 8'h02);
         check("mul_busy_valid", 8'(out_valid), 8'h00);
         step();
      end
      check("mul_valid", 8'(out_valid), 8'h01);
      check("mul_done_alu_op", 8'(alu_op), 8'h00);
      check("mul_result", out_result, 8'hE1);
      check("mul_flags", {5'b0, out_cout, out_overflow, out_zero}, 8'b000);
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // MUL 0*15, reserved command code
      in_valid = 1'b1; in_cmd = 4'b1101; in_a = 4'b0000; in_b = 4'b1111;
      step(); in_valid = 1'b0;
      step(); step(); step(); step();
      check("mul0_result", out_result, 8'h00);
      check("mul0_zero", 8'(out_zero), 8'h01);
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // ADD 5+5 leaves a nonzero result, then MUL interrupted by reset
      in_valid = 1'b1; in_cmd = 4'b0010; in_a = 4'b0101; in_b = 4'b0101;
      step(); in_valid = 1'b0; step();
      check("pre_rst_result", out_result, 8'h0A);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      in_valid = 1'b1; in_cmd = 4'b1000; in_a = 4'b1111; in_b = 4'b1111;
      step(); in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("rst_mid_in_ready", 8'(in_ready), 8'h01);
      check("rst_mid_valid", 8'(out_valid), 8'h00);
      check("rst_mid_result", out_result, 8'h00);
      check("rst_mid_alu_op", 8'(alu_op), 8'h00);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("post_rst_no_valid", 8'(out_valid), 8'h00);
      end

      // MUL 3*5 completes normally
      in_valid = 1'b1; in_cmd = 4'b1000; in_a = 4'b0011; in_b = 4'b0101;
      step(); in_valid = 1'b0;
      step(); step(); step(); step();
      check("post_rst_mul_valid", 8'(out_valid), 8'h01);
      check("post_rst_mul_result", out_result, 8'h0F);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      check("final_in_ready", 8'(in_ready), 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width; only 4 is supported, matching the 4-bit ALU.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  command valid.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept a command.
REQ-006 SHALL have port in_cmd  input  4  bit 3 set = MUL; bit 3 clear = single ALU op with in_cmd[2:0] as ALU op code.
REQ-007 SHALL have port in_a  input  4  operand A, or unsigned multiplicand for MUL.
REQ-008 SHALL have port in_b  input  4  operand B, or unsigned multiplier for MUL.
REQ-009 SHALL have port alu_a  output  4  ALU operand A.
REQ-010 SHALL have port alu_b  output  4  ALU operand B.
REQ-011 SHALL have port alu_op  output  3  ALU op code; bit 2 is also the ALU carry-in/b-invert.
REQ-012 SHALL have port alu_result  input  4  ALU result.
REQ-013 SHALL have ports alu_cout, alu_overflow, alu_zero  input  1 each  ALU flags.
REQ-014 SHALL have port out_valid  output  1  result available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts result.
REQ-016 SHALL have port out_result  output  8  result; single op in [3:0] with [7:4]=0; MUL is the full 8-bit product.
REQ-017 SHALL have ports out_cout, out_overflow, out_zero  output  1 each  registered flags.

Function
REQ-018 SHALL implement FSM states IDLE, EXEC, MUL, DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; a command is accepted on an edge where in_valid and in_ready are both 1.
REQ-020 On accept, SHALL register operands and command, then go to EXEC if in_cmd[3]=0, else to MUL.
REQ-021 MUL SHALL load P_hi=0, Q=in_b, M=in_a and iteration count 0.
REQ-022 In EXEC, alu_a/alu_b/alu_op SHALL equal the registered operands and op code, combinationally from registers.
REQ-023 On the EXEC edge, SHALL capture out_result={4'b0,alu_result} and the cout/overflow/zero flags, then go to DONE.
REQ-024 Single-op latency SHALL be exactly 1 cycle: out_valid rises after the edge following accept.
REQ-025 In MUL, SHALL drive alu_a=P_hi, alu_b=(Q[0] ? M : 0) and alu_op=3'b010 (ADD).
REQ-026 Each MUL edge SHALL shift {alu_cout, alu_result, Q} right by 1 into {P_hi, Q}.
REQ-027 MUL SHALL perform exactly 4 iterations, then load out_result={P_hi,Q} and go to DONE.
REQ-028 MUL latency SHALL be 4 cycles after accept.
REQ-029 For MUL, out_zero SHALL be (product==0), with out_cout=0 and out_overflow=0.
REQ-030 In IDLE and DONE, alu_a, alu_b and alu_op SHALL be 0.
REQ-031 In DONE, out_valid SHALL be 1 and out_* SHALL be held stable until out_ready=1.
REQ-032 On out_valid and out_ready both 1, SHALL return to IDLE; no new command is accepted on that same edge.
REQ-033 in_cmd values with bit 3 set and [2:0] nonzero are reserved and SHALL execute as MUL.
REQ-034 Single-op codes SHALL pass to the ALU unchanged, including unused codes.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, even mid-EXEC or mid-MUL.
REQ-036 rst_n low SHALL clear out_valid, out_result, all out flags, operand registers and iteration count to 0, leaving in_ready=1.
REQ-037 A command in flight at reset SHALL be discarded, with no out_valid pulse.

Verification
REQ-038 SHALL test ADD: in_cmd=0010, a=0111, b=0111 -> 1 cycle later out_result=0x0E, out_overflow=1, out_cout=0, out_zero=0.
REQ-039 SHALL test SUB: in_cmd=0110, a=0111, b=0111 -> out_result=0x00, out_zero=1, out_overflow=0.
REQ-040 SHALL test SLT: in_cmd=0111, a=1001, b=1111 -> out_result=0x01; swapped operands -> 0x00.
REQ-041 SHALL test MUL: in_cmd=1000, a=1111, b=1111 -> alu_op=010 for exactly 4 cycles, then out_result=0xE1, out_zero=0; a=0000 -> 0x00, out_zero=1.
REQ-042 SHALL test backpressure: out_ready=0 for 5 cycles after DONE -> out_valid and out_result stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-043 SHALL test reset: rst_n pulsed low during MUL iteration 2 -> immediate IDLE, out_valid=0, out_result=0; the next command completes normally.
